// File: rtl/tlight_pkg.sv
// -----------------------------------------------------------------------------
// tlight_pkg
// Shared types and defaults for the traffic-light pacing timer.
//   phase_t       : decoded lamp phase (GREEN, AMBER, RED, RED_AMBER, INVALID)
//   decode_phase  : maps the fed-back {r,a,g} lamp code onto phase_t
//   DEF_*         : default dwell lengths in clock cycles
// Optional build macro used by the top level: TLIGHT_TIMER_NIGHT_EN.
// -----------------------------------------------------------------------------
package tlight_pkg;

   typedef enum logic [2:0] {
      GREEN     = 3'd0,
      AMBER     = 3'd1,
      RED       = 3'd2,
      RED_AMBER = 3'd3,
      INVALID   = 3'd4
   } phase_t;

   localparam int DEF_CNT_W            = 8;
   localparam int DEF_GREEN_CYCLES     = 20;
   localparam int DEF_AMBER_CYCLES     = 4;
   localparam int DEF_RED_CYCLES       = 20;
   localparam int DEF_RED_AMBER_CYCLES = 3;
   localparam int DEF_MIN_GREEN_CYCLES = 8;
   localparam int DEF_PED_EXTRA_CYCLES = 10;

   function automatic phase_t decode_phase(input logic r, input logic a, input logic g);
      phase_t ph;
      case ({r, a, g})
         3'b001:  ph = GREEN;
         3'b010:  ph = AMBER;
         3'b100:  ph = RED;
         3'b110:  ph = RED_AMBER;
         default: ph = INVALID;
      endcase
      return ph;
   endfunction

endpackage

// File: rtl/tlight_dwell_cnt.sv
// -----------------------------------------------------------------------------
// tlight_dwell_cnt
// Detects phase changes, tracks cycles elapsed in the current phase and raises
// step once the supplied dwell has been reached.
// Ports:
//   clk, rst    : clock, synchronous active-high reset
//   phase       : decoded current phase
//   dwell       : dwell (cycles) the current phase must be visible for, >= 1
//   phase_chg   : current phase differs from the previous cycle's phase
//   step        : elapsed >= dwell-1, or phase is INVALID
// -----------------------------------------------------------------------------
module tlight_dwell_cnt
   import tlight_pkg::*;
#(
   parameter int CNT_W = DEF_CNT_W
) (
   input  logic             clk,
   input  logic             rst,
   input  phase_t           phase,
   input  logic [CNT_W-1:0] dwell,
   output logic             phase_chg,
   output logic             step
);

   localparam logic [CNT_W-1:0] CNT_MAX = '1;

   phase_t           prev_phase_reg;
   logic [CNT_W-1:0] cnt_reg;
   logic [CNT_W-1:0] cnt_next;
   logic [CNT_W-1:0] elapsed;

   assign phase_chg = (phase != prev_phase_reg);
   // A fresh phase starts counting from zero in its very first cycle.
   assign elapsed   = phase_chg ? '0 : cnt_reg;

   always_comb begin
      cnt_next = '0;
      if (phase != INVALID) begin
         // Saturate so a sequencer that ignores step keeps step asserted.
         cnt_next = (elapsed == CNT_MAX) ? CNT_MAX : elapsed + 1'b1;
      end
   end

   // INVALID forces step so the sequencer can walk itself back to a legal code.
   assign step = (phase == INVALID) || (elapsed >= dwell - 1'b1);

   always_ff @(posedge clk) begin
      if (rst) begin
         prev_phase_reg <= INVALID;
         cnt_reg        <= '0;
      end else begin
         prev_phase_reg <= phase;
         cnt_reg        <= cnt_next;
      end
   end

endmodule

// File: rtl/tlight_timer.sv
// -----------------------------------------------------------------------------
// tlight_timer
// Pacing stage for the r/a/g sequencer: decodes the fed-back lamps, times a
// per-phase dwell and issues step on the last cycle of each phase. Handles
// pedestrian requests (shortened green, extended red with walk lamp).
// Ports:
//   clk, rst     : clock, synchronous active-high reset
//   r, a, g      : lamp outputs fed back from the sequencer
//   btn          : pedestrian button (synchronous, level-sensitive)
//   night        : (only with TLIGHT_TIMER_NIGHT_EN) hold green while idle
//   step         : advance enable to the sequencer (combinational)
//   walk         : walk lamp, registered
//   req_pending  : pedestrian request latched and not yet served, registered
//   fault        : r/a/g code was not a legal phase, registered
// Build macro: TLIGHT_TIMER_NIGHT_EN adds the night input.
// -----------------------------------------------------------------------------
module tlight_timer
   import tlight_pkg::*;
#(
   parameter int CNT_W            = DEF_CNT_W,
   parameter int GREEN_CYCLES     = DEF_GREEN_CYCLES,
   parameter int AMBER_CYCLES     = DEF_AMBER_CYCLES,
   parameter int RED_CYCLES       = DEF_RED_CYCLES,
   parameter int RED_AMBER_CYCLES = DEF_RED_AMBER_CYCLES,
   parameter int MIN_GREEN_CYCLES = DEF_MIN_GREEN_CYCLES,
   parameter int PED_EXTRA_CYCLES = DEF_PED_EXTRA_CYCLES
) (
   input  logic clk,
   input  logic rst,
   input  logic r,
   input  logic a,
   input  logic g,
   input  logic btn,
`ifdef TLIGHT_TIMER_NIGHT_EN
   input  logic night,
`endif
   output logic step,
   output logic walk,
   output logic req_pending,
   output logic fault
);

   localparam logic [CNT_W-1:0] D_GREEN     = CNT_W'(GREEN_CYCLES);
   localparam logic [CNT_W-1:0] D_MIN_GREEN = CNT_W'(MIN_GREEN_CYCLES);
   localparam logic [CNT_W-1:0] D_AMBER     = CNT_W'(AMBER_CYCLES);
   localparam logic [CNT_W-1:0] D_RED       = CNT_W'(RED_CYCLES);
   localparam logic [CNT_W-1:0] D_RED_EXT   = CNT_W'(RED_CYCLES + PED_EXTRA_CYCLES);
   localparam logic [CNT_W-1:0] D_RED_AMBER = CNT_W'(RED_AMBER_CYCLES);

   phase_t           phase;
   logic             phase_chg;
   logic             step_raw;
   logic             night_hold;
   logic             serve_now;
   logic             served_cur;
   logic [CNT_W-1:0] dwell;
   logic             req_reg;
   logic             walk_reg;
   logic             fault_reg;
   logic             served_reg;

   assign phase = decode_phase(r, a, g);

   // A red is served when it is entered with a request latched; the flag then
   // persists for the remainder of that red so its dwell stays extended.
   assign serve_now  = phase_chg && (phase == RED) && req_reg;
   assign served_cur = (phase == RED) && (serve_now || (served_reg && !phase_chg));

   always_comb begin
      dwell = D_GREEN;
      case (phase)
         GREEN:     dwell = req_reg ? D_MIN_GREEN : D_GREEN;
         AMBER:     dwell = D_AMBER;
         RED:       dwell = served_cur ? D_RED_EXT : D_RED;
         RED_AMBER: dwell = D_RED_AMBER;
         default:   dwell = D_GREEN;
      endcase
   end

   tlight_dwell_cnt #(
      .CNT_W (CNT_W)
   ) u_dwell_cnt (
      .clk       (clk),
      .rst       (rst),
      .phase     (phase),
      .dwell     (dwell),
      .phase_chg (phase_chg),
      .step      (step_raw)
   );

`ifdef TLIGHT_TIMER_NIGHT_EN
   // Elapsed keeps counting while held, so releasing may step immediately.
   assign night_hold = night && !req_reg && (phase == GREEN);
`else
   assign night_hold = 1'b0;
`endif

   assign step = step_raw && !night_hold;

   always_ff @(posedge clk) begin
      if (rst) begin
         req_reg    <= 1'b0;
         walk_reg   <= 1'b0;
         fault_reg  <= 1'b0;
         served_reg <= 1'b0;
      end else begin
         served_reg <= served_cur;
         fault_reg  <= (phase == INVALID);
         if (serve_now) begin
            // A press coinciding with red entry is kept for the next red.
            req_reg  <= btn;
            walk_reg <= 1'b1;
         end else begin
            if (btn) begin
               req_reg <= 1'b1;
            end
            if (phase != RED) begin
               walk_reg <= 1'b0;
            end
         end
      end
   end

   assign walk        = walk_reg;
   assign req_pending = req_reg;
   assign fault       = fault_reg;

endmodule

// File: tb/tb_tlight_timer.sv
// -----------------------------------------------------------------------------
// tb_tlight_timer
// Closed-loop bench: a behavioural r/a/g sequencer advances on step. Expected
// phase completions (lamp code, visible length, walk, req_pending on the last
// cycle) are queued by the stimulus and checked by a monitor on every step.
// -----------------------------------------------------------------------------
module tb_tlight_timer;

   localparam logic [2:0] C_G  = 3'b001;
   localparam logic [2:0] C_A  = 3'b010;
   localparam logic [2:0] C_R  = 3'b100;
   localparam logic [2:0] C_RA = 3'b110;

   typedef struct {
      logic [2:0] code;
      int         len;
      logic       walk;
      logic       req;
   } exp_t;

   logic clk;
   logic rst;
   logic r, a, g;
   logic btn;
   logic step, walk, req_pending, fault;
`ifdef TLIGHT_TIMER_NIGHT_EN
   logic night;
`endif

   int         seq_phase;
   logic       force_en;
   logic [2:0] force_code;
   logic [2:0] rag;
   int         len;
   exp_t       exp_q[$];
   int         checks;
   int         errors;

   tlight_timer dut (
      .clk         (clk),
      .rst         (rst),
      .r           (r),
      .a           (a),
      .g           (g),
      .btn         (btn),
`ifdef TLIGHT_TIMER_NIGHT_EN
      .night       (night),
`endif
      .step        (step),
      .walk        (walk),
      .req_pending (req_pending),
      .fault       (fault)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [2:0] code_of(input int ph);
      logic [2:0] c;
      case (ph)
         0:       c = C_G;
         1:       c = C_A;
         2:       c = C_R;
         default: c = C_RA;
      endcase
      return c;
   endfunction

   assign rag       = force_en ? force_code : code_of(seq_phase);
   assign {r, a, g} = rag;

   task automatic chk(input string name, input int act, input int req);
      checks++;
      if (act != req) begin
         errors++;
         $display("FAIL %s actual=%0d required=%0d", name, act, req);
      end
   endtask

   task automatic push(input logic [2:0] code, input int n, input logic w, input logic q);
      exp_t e;
      e.code = code;
      e.len  = n;
      e.walk = w;
      e.req  = q;
      exp_q.push_back(e);
   endtask

   // Sequencer model: samples step mid-cycle, changes lamps just after the edge.
   initial begin
      logic do_adv;
      seq_phase = 0;
      forever begin
         @(negedge clk);
         do_adv = step && !force_en && !rst;
         @(posedge clk);
         #1;
         if (rst) seq_phase = 0;
         else if (do_adv) seq_phase = (seq_phase + 1) % 4;
      end
   end

   // Monitor: tracks visible phase length and scores every step pulse.
   initial begin
      logic [2:0] last;
      exp_t e;
      len  = 0;
      last = 3'b000;
      forever begin
         @(negedge clk);
         if (rst) begin
            len  = 0;
            last = rag;
         end else begin
            if (rag == last) len++;
            else len = 1;
            last = rag;
            if (step && !force_en) begin
               $display("step code=%b len=%0d walk=%b req=%b", rag, len, walk, req_pending);
               if (exp_q.size() == 0) begin
                  chk("unexpected_step", 1, 0);
               end else begin
                  e = exp_q.pop_front();
                  chk("step_code", int'(rag), int'(e.code));
                  chk("step_len", len, e.len);
                  chk("step_walk", int'(walk), int'(e.walk));
                  chk("step_req", int'(req_pending), int'(e.req));
               end
            end
         end
      end
   end

   task automatic wait_q_empty();
      for (int i = 0; i < 1000; i++) begin
         @(negedge clk);
         #1;
         if (exp_q.size() == 0) return;
      end
      chk("queue_drain_timeout", exp_q.size(), 0);
      exp_q.delete();
   endtask

   task automatic wait_phase_len(input logic [2:0] code, input int n);
      for (int i = 0; i < 1000; i++) begin
         @(negedge clk);
         #1;
         if (!force_en && rag == code && len == n) return;
      end
      chk("phase_wait_timeout", 1, 0);
   endtask

   task automatic pulse_btn();
      btn = 1'b1;
      @(negedge clk);
      #1;
      btn = 1'b0;
   endtask

   initial begin
      checks     = 0;
      errors     = 0;
      rst        = 1'b1;
      btn        = 1'b0;
      force_en   = 1'b0;
      force_code = 3'b000;
`ifdef TLIGHT_TIMER_NIGHT_EN
      night      = 1'b0;
`endif
      repeat (3) @(posedge clk);
      @(negedge clk);
      #1;
      chk("rst_walk", int'(walk), 0);
      chk("rst_req", int'(req_pending), 0);
      chk("rst_fault", int'(fault), 0);
      chk("rst_step", int'(step), 0);

      // Free-running cycle, no requests.
      push(C_G, 20, 1'b0, 1'b0);
      push(C_A, 4, 1'b0, 1'b0);
      push(C_R, 20, 1'b0, 1'b0);
      push(C_RA, 3, 1'b0, 1'b0);
      @(posedge clk);
      #2;
      rst = 1'b0;
      wait_q_empty();

      // Early press: green cut to 8, served red of 30 with walk.
      push(C_G, 8, 1'b0, 1'b1);
      push(C_A, 4, 1'b0, 1'b1);
      push(C_R, 30, 1'b1, 1'b0);
      push(C_RA, 3, 1'b0, 1'b0);
      wait_phase_len(C_G, 4);
      pulse_btn();
      chk("btn_to_req", int'(req_pending), 1);
      wait_q_empty();

      // Late press: step as soon as req is visible, green totals 17.
      push(C_G, 17, 1'b0, 1'b1);
      push(C_A, 4, 1'b0, 1'b1);
      push(C_R, 30, 1'b1, 1'b0);
      push(C_RA, 3, 1'b0, 1'b0);
      wait_phase_len(C_G, 16);
      pulse_btn();
      wait_q_empty();

      // Illegal lamp code mid-green.
      wait_phase_len(C_G, 5);
      @(posedge clk);
      #2;
      force_en = 1'b1;
      @(negedge clk);
      #1;
      chk("inv_step0", int'(step), 1);
      chk("inv_fault0", int'(fault), 0);
      @(negedge clk);
      #1;
      chk("inv_step1", int'(step), 1);
      chk("inv_fault1", int'(fault), 1);
      push(C_G, 20, 1'b0, 1'b0);
      @(posedge clk);
      #2;
      force_en = 1'b0;
      @(negedge clk);
      @(negedge clk);
      #1;
      chk("fault_clear", int'(fault), 0);
      wait_q_empty();

      // Reset during a served red with a fresh request pending.
      push(C_A, 4, 1'b0, 1'b1);
      wait_phase_len(C_A, 1);
      pulse_btn();
      wait_q_empty();
      wait_phase_len(C_R, 5);
      pulse_btn();
      chk("red_walk", int'(walk), 1);
      chk("red_req", int'(req_pending), 1);
      rst = 1'b1;
      @(negedge clk);
      #1;
      chk("mid_rst_walk", int'(walk), 0);
      chk("mid_rst_req", int'(req_pending), 0);
      chk("mid_rst_fault", int'(fault), 0);
      push(C_G, 20, 1'b0, 1'b0);
      push(C_A, 4, 1'b0, 1'b0);
      push(C_R, 20, 1'b0, 1'b0);
      push(C_RA, 3, 1'b0, 1'b0);
      @(posedge clk);
      #2;
      rst = 1'b0;
      wait_q_empty();

`ifdef TLIGHT_TIMER_NIGHT_EN
      // Night hold: green never times out until a request arrives.
      night = 1'b1;
      push(C_G, 111, 1'b0, 1'b1);
      push(C_A, 4, 1'b0, 1'b1);
      push(C_R, 30, 1'b1, 1'b0);
      push(C_RA, 3, 1'b0, 1'b0);
      wait_phase_len(C_G, 100);
      chk("night_hold_step", int'(step), 0);
      wait_phase_len(C_G, 110);
      pulse_btn();
      wait_q_empty();
      night = 1'b0;
`endif

      repeat (5) @(negedge clk);
      chk("queue_left", exp_q.size(), 0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
